// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU port, the DMA/loader port, the arbiter and the memory macro.
// slave: the arbiter's view. master: the view of the requesters and the memory macro.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          cpu_stall;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic [DW-1:0] dma_rdata;
  logic          dma_ack;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the unified instruction/data memory between the CPU
// and a DMA/loader port. One access at a time: IDLE -> ACCESS (MEM_LAT cycles of
// mem_en) -> RESP (one-cycle ack) -> IDLE.
// Build option ARB_RR_EN: round-robin on simultaneous requests; when undefined,
// the CPU has fixed priority.
//
// state  | meaning
// IDLE   | waiting; requests sampled at the clock edge
// ACCESS | mem_en high, latched request driven to memory, counting down
// RESP   | one-cycle ack to the granted port
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus_io
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gnt_q, gnt_d;      // 1 = DMA owns the current access
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dma_rdata_q, dma_rdata_d;

  logic any_req;
  logic win_dma;

  assign any_req = bus_io.cpu_req | bus_io.dma_req;

`ifdef ARB_RR_EN
  logic last_gnt_q, last_gnt_d;

  assign win_dma = bus_io.dma_req & (~bus_io.cpu_req | ~last_gnt_q);

  // Remember who won the last arbitration so a tie goes to the other port.
  always_comb begin
    last_gnt_d = last_gnt_q;
    if (state_q == S_IDLE && any_req) begin
      last_gnt_d = win_dma;
    end
  end

  // last_grant register; starts at DMA so the first tie goes to the CPU.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_gnt_q <= 1'b1;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end
`else
  assign win_dma = ~bus_io.cpu_req;
`endif

  // Next-state logic: arbitration, request latching, countdown and read capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_ACCESS;
          gnt_d   = win_dma;
          we_d    = win_dma ? bus_io.dma_we    : bus_io.cpu_we;
          addr_d  = win_dma ? bus_io.dma_addr  : bus_io.cpu_addr;
          wdata_d = win_dma ? bus_io.dma_wdata : bus_io.cpu_wdata;
          cnt_d   = CNT_LOAD;
        end
      end
      S_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = S_RESP;
          if (!we_q) begin
            if (gnt_q) dma_rdata_d = bus_io.mem_rdata;
            else       cpu_rdata_d = bus_io.mem_rdata;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      gnt_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  assign bus_io.mem_en    = (state_q == S_ACCESS);
  assign bus_io.mem_we    = (state_q == S_ACCESS) & we_q;
  assign bus_io.mem_addr  = addr_q;
  assign bus_io.mem_wdata = wdata_q;
  assign bus_io.busy      = (state_q == S_ACCESS) | (state_q == S_RESP);

  assign bus_io.cpu_ack   = (state_q == S_RESP) & ~gnt_q;
  assign bus_io.dma_ack   = (state_q == S_RESP) &  gnt_q;
  assign bus_io.cpu_stall = bus_io.cpu_req & ~bus_io.cpu_ack;

  assign bus_io.cpu_rdata = cpu_rdata_q;
  assign bus_io.dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. Two instances (MEM_LAT=2 and MEM_LAT=1) share the
// stimulus; only the selected one is out of reset and observed. The reference is
// a transaction-level model: each granted access is a cycle window
// [start+1 .. start+lat] of memory activity followed by an ack at start+lat+1.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic sel   = 1'b0;
  logic rst_a, rst_b;
  assign rst_a = rst_n & ~sel;
  assign rst_b = rst_n &  sel;

  logic          cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0, dma_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, dma_wdata = '0, mem_rdata = '0;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) if_a ();
  mem_port_arbiter_if #(.AW(AW), .DW(DW)) if_b ();

  assign if_a.cpu_req   = cpu_req;   assign if_b.cpu_req   = cpu_req;
  assign if_a.cpu_we    = cpu_we;    assign if_b.cpu_we    = cpu_we;
  assign if_a.cpu_addr  = cpu_addr;  assign if_b.cpu_addr  = cpu_addr;
  assign if_a.cpu_wdata = cpu_wdata; assign if_b.cpu_wdata = cpu_wdata;
  assign if_a.dma_req   = dma_req;   assign if_b.dma_req   = dma_req;
  assign if_a.dma_we    = dma_we;    assign if_b.dma_we    = dma_we;
  assign if_a.dma_addr  = dma_addr;  assign if_b.dma_addr  = dma_addr;
  assign if_a.dma_wdata = dma_wdata; assign if_b.dma_wdata = dma_wdata;
  assign if_a.mem_rdata = mem_rdata; assign if_b.mem_rdata = mem_rdata;

  logic          o_cpu_ack, o_dma_ack, o_cpu_stall, o_mem_en, o_mem_we, o_busy;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata, o_cpu_rdata, o_dma_rdata;
  assign o_cpu_ack   = sel ? if_b.cpu_ack   : if_a.cpu_ack;
  assign o_dma_ack   = sel ? if_b.dma_ack   : if_a.dma_ack;
  assign o_cpu_stall = sel ? if_b.cpu_stall : if_a.cpu_stall;
  assign o_mem_en    = sel ? if_b.mem_en    : if_a.mem_en;
  assign o_mem_we    = sel ? if_b.mem_we    : if_a.mem_we;
  assign o_busy      = sel ? if_b.busy      : if_a.busy;
  assign o_mem_addr  = sel ? if_b.mem_addr  : if_a.mem_addr;
  assign o_mem_wdata = sel ? if_b.mem_wdata : if_a.mem_wdata;
  assign o_cpu_rdata = sel ? if_b.cpu_rdata : if_a.cpu_rdata;
  assign o_dma_rdata = sel ? if_b.dma_rdata : if_a.dma_rdata;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(2)) u_dut_a (
    .clk   (clk),
    .rst   (rst_a),
    .bus_io(if_a.slave)
  );

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1)) u_dut_b (
    .clk   (clk),
    .rst   (rst_b),
    .bus_io(if_b.slave)
  );

  // counters and model state
  int total = 0;
  int bad   = 0;
  int k     = 0;
  int lat   = 2;
  int c_start = -1000;
  bit m_grant = 1'b0;   // 1 = DMA
  bit m_we    = 1'b0;
  bit m_last  = 1'b1;
  logic [31:0] m_addr = '0, m_wdata = '0, e_crd = '0, e_drd = '0;
  bit e_cack = 1'b0, e_dack = 1'b0;
  logic ob_cack, ob_dack, ob_en, ob_we, ob_stall;
  logic [31:0] ob_addr, ob_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", nm, k, act, exp);
    end
  endtask

  task automatic model_reset();
    c_start = -1000;
    m_grant = 1'b0;
    m_we    = 1'b0;
    m_last  = 1'b1;
    m_addr  = '0;
    m_wdata = '0;
    e_crd   = '0;
    e_drd   = '0;
  endtask

  // One cycle: compare at the falling edge, advance the model, return at posedge+1.
  task automatic step();
    bit in_acc, in_resp, win;
    @(negedge clk);
    in_acc  = (k > c_start) && (k <= c_start + lat);
    in_resp = (k == c_start + lat + 1);
    e_cack  = in_resp && !m_grant;
    e_dack  = in_resp &&  m_grant;
    chk("mem_en",    32'(o_mem_en),    32'(in_acc));
    chk("mem_we",    32'(o_mem_we),    32'(in_acc && m_we));
    chk("mem_addr",  o_mem_addr,       m_addr);
    chk("mem_wdata", o_mem_wdata,      m_wdata);
    chk("busy",      32'(o_busy),      32'(in_acc || in_resp));
    chk("cpu_ack",   32'(o_cpu_ack),   32'(e_cack));
    chk("dma_ack",   32'(o_dma_ack),   32'(e_dack));
    chk("cpu_stall", 32'(o_cpu_stall), 32'(cpu_req && !e_cack));
    chk("cpu_rdata", o_cpu_rdata,      e_crd);
    chk("dma_rdata", o_dma_rdata,      e_drd);
    ob_cack = o_cpu_ack;  ob_dack = o_dma_ack; ob_en = o_mem_en; ob_we = o_mem_we;
    ob_stall = o_cpu_stall; ob_addr = o_mem_addr; ob_wdata = o_mem_wdata;
    if (k == c_start + lat && !m_we) begin
      if (m_grant) e_drd = mem_rdata;
      else         e_crd = mem_rdata;
    end
    if (k >= c_start + lat + 2 && (cpu_req || dma_req)) begin
`ifdef ARB_RR_EN
      win = (cpu_req && dma_req) ? !m_last : !cpu_req;
`else
      win = !cpu_req;
`endif
      c_start = k;
      m_grant = win;
      m_last  = win;
      m_we    = win ? dma_we    : cpu_we;
      m_addr  = win ? dma_addr  : cpu_addr;
      m_wdata = win ? dma_wdata : cpu_wdata;
    end
    k++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cpu_req = 1'b0;
    dma_req = 1'b0;
    rst_n   = 1'b0;
    model_reset();
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Random requesters: hold until ack, sometimes re-request at once, and
  // scramble the granted port's fields mid-access (they must have been latched).
  task automatic agents();
    bit in_acc;
    mem_rdata = $urandom;
    in_acc = (k > c_start) && (k <= c_start + lat);
    if (cpu_req && e_cack) cpu_req = 1'b0;
    if (!cpu_req && $urandom_range(0, 2) == 0) begin
      cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
      cpu_addr = $urandom_range(0, 255); cpu_wdata = $urandom;
    end else if (cpu_req && in_acc && !m_grant && $urandom_range(0, 1) == 0) begin
      cpu_we = ~cpu_we; cpu_addr = $urandom; cpu_wdata = $urandom;
    end
    if (dma_req && e_dack) dma_req = 1'b0;
    if (!dma_req && $urandom_range(0, 2) == 0) begin
      dma_req = 1'b1; dma_we = 1'($urandom_range(0, 1));
      dma_addr = $urandom_range(256, 511); dma_wdata = $urandom;
    end else if (dma_req && in_acc && m_grant && $urandom_range(0, 1) == 0) begin
      dma_we = ~dma_we; dma_addr = $urandom; dma_wdata = $urandom;
    end
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      agents();
      step();
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;
    for (int i = 0; i < 6; i++) step();
  endtask

  initial begin
    int got, n_en, tc, td, n_ack;
    int ord[4];
    int exp_ord[4];

    @(posedge clk);
    #1;
    do_reset();

    // T1: CPU read at 0x10 returning 0xDEADBEEF
    mem_rdata = 32'hDEADBEEF;
    cpu_we = 1'b0; cpu_addr = 32'h10; cpu_req = 1'b1;
    got = -1; n_en = 0;
    for (int i = 0; i < 12 && got < 0; i++) begin
      step();
      if (ob_en) begin
        n_en++;
        chk("t1_addr", ob_addr, 32'h10);
        chk("t1_we", 32'(ob_we), 32'd0);
      end
      if (ob_cack) begin got = i; cpu_req = 1'b0; end
    end
    chk("t1_ack_latency", got, 32'd3);
    chk("t1_en_cycles", n_en, 32'd2);
    chk("t1_rdata", o_cpu_rdata, 32'hDEADBEEF);

    // T2: DMA write 0x55 to 0x20
    mem_rdata = 32'h0BAD_F00D;
    dma_we = 1'b1; dma_addr = 32'h20; dma_wdata = 32'h55; dma_req = 1'b1;
    got = -1; n_en = 0;
    for (int i = 0; i < 12 && got < 0; i++) begin
      step();
      if (ob_en) begin
        n_en++;
        chk("t2_we", 32'(ob_we), 32'd1);
        chk("t2_wdata", ob_wdata, 32'h55);
        chk("t2_addr", ob_addr, 32'h20);
      end
      if (ob_dack) begin got = i; dma_req = 1'b0; end
    end
    chk("t2_ack_latency", got, 32'd3);
    chk("t2_en_cycles", n_en, 32'd2);
    chk("t2_cpu_rdata", o_cpu_rdata, 32'hDEADBEEF);
    chk("t2_dma_rdata", o_dma_rdata, 32'h0);

    // T3: simultaneous requests, CPU served first
    cpu_we = 1'b0; cpu_addr = 32'h30; dma_we = 1'b0; dma_addr = 32'h40;
    cpu_req = 1'b1; dma_req = 1'b1;
    tc = -1; td = -1;
    for (int i = 0; i < 20 && (tc < 0 || td < 0); i++) begin
      step();
      if (ob_cack) begin tc = i; cpu_req = 1'b0; end
      if (ob_dack) begin td = i; dma_req = 1'b0; end
    end
    chk("t3_cpu_ack", tc, 32'd3);
    chk("t3_dma_ack", td, 32'd7);
    cpu_req = 1'b0; dma_req = 1'b0;

    // T4: both ports re-requesting continuously after reset
    do_reset();
`ifdef ARB_RR_EN
    exp_ord = '{0, 1, 0, 1};
`else
    exp_ord = '{0, 0, 0, 0};
`endif
    ord = '{-1, -1, -1, -1};
    cpu_req = 1'b1; dma_req = 1'b1; n_ack = 0;
    for (int i = 0; i < 40 && n_ack < 4; i++) begin
      step();
      if (ob_cack) begin ord[n_ack] = 0; n_ack++; end
      else if (ob_dack) begin ord[n_ack] = 1; n_ack++; end
    end
    for (int i = 0; i < 4; i++) chk($sformatf("t4_grant%0d", i), ord[i], exp_ord[i]);
    cpu_req = 1'b0; dma_req = 1'b0;
    for (int i = 0; i < 6; i++) step();

    // T5: reset during the second ACCESS cycle of a CPU read
    mem_rdata = 32'h1234_5678;
    cpu_we = 1'b0; cpu_addr = 32'h50; cpu_req = 1'b1;
    step();
    step();
    chk("t5_en_before", 32'(o_mem_en), 32'd1);
    #2;
    rst_n = 1'b0;
    cpu_req = 1'b0;
    model_reset();
    #1;
    chk("t5_en_async", 32'(o_mem_en), 32'd0);
    chk("t5_busy_async", 32'(o_busy), 32'd0);
    chk("t5_ack_async", 32'({o_cpu_ack, o_dma_ack}), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    mem_rdata = 32'hA5A5_0F0F;
    cpu_addr = 32'h60; cpu_req = 1'b1;
    got = -1;
    for (int i = 0; i < 12 && got < 0; i++) begin
      step();
      if (ob_cack) begin got = i; cpu_req = 1'b0; end
    end
    chk("t5_ack_latency", got, 32'd3);
    chk("t5_rdata", o_cpu_rdata, 32'hA5A5_0F0F);

    run_random(400);

    // switch to the MEM_LAT=1 instance
    cpu_req = 1'b0; dma_req = 1'b0;
    rst_n = 1'b0;
    sel = 1'b1;
    lat = 1;
    do_reset();

    // T6: back-to-back CPU reads with MEM_LAT=1
    cpu_we = 1'b0; cpu_addr = 32'h70; cpu_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      mem_rdata = 32'hC0DE_0000 + 32'(i);
      step();
      chk("t6_ack", 32'(ob_cack), 32'(i % 3 == 2));
      chk("t6_stall", 32'(ob_stall), 32'(i % 3 != 2));
    end
    cpu_req = 1'b0;
    for (int i = 0; i < 4; i++) step();

    run_random(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d got=timeout want=finish", k);
    $fatal(1, "watchdog");
  end

endmodule
